// File: rtl/fp_issue_scheduler.sv
// In-order FP issue stage: pops instruction headers, tracks per-register busy bits,
// issues arithmetic ops to the FP ALU and commits LOAD data into the register file.
module fp_issue_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_rdata,
    output logic        fifo_pop,
    input  logic        data_avail,
    input  logic [31:0] data_in,
    output logic        data_pop,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        alu_ready,
    output logic        alu_issue,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_src1,
    output logic [3:0]  alu_src2,
    output logic [3:0]  alu_dest,
    input  logic        alu_done,
    input  logic [3:0]  alu_done_dest,
    output logic [15:0] dependency_remove,
    output logic        illegal_op,
    output logic [15:0] busy_o
);

    localparam logic [3:0] MAX_INFLIGHT_C = 4'(MAX_INFLIGHT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_BINARY  = 3'd2,
        CLS_UNARY   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'h0, 4'h1, 4'hA: cls = CLS_NONE;
            4'h2:             cls = CLS_LOAD;
            4'h3, 4'h4, 4'h5: cls = CLS_BINARY;
            4'h6, 4'h7,
            4'h8, 4'h9:       cls = CLS_UNARY;
            default:          cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] busy_q, busy_d;
    logic [3:0]  inflight_q, inflight_d;

    logic [3:0]  op_s, dest_s, src1_s, src2_s;
    op_class_t   cls_s;
    logic        done_hit_s;
    logic [15:0] done_mask_s;
    logic [15:0] issue_mask_s;
    logic [15:0] load_mask_s;
    logic        alu_clear_s;
    logic        load_clear_s;

    assign op_s   = inst_q[15:12];
    assign dest_s = inst_q[11:8];
    assign src1_s = inst_q[7:4];
    assign src2_s = inst_q[3:0];
    assign cls_s  = classify(op_s);
    assign busy_o = busy_q;

    // A completion only counts when it names a register we actually marked busy.
    always_comb begin
        done_hit_s  = alu_done & busy_q[alu_done_dest];
        done_mask_s = 16'h0000;
        if (done_hit_s) begin
            done_mask_s = reg_onehot(alu_done_dest);
        end else begin
            done_mask_s = 16'h0000;
        end
    end

    // Hazard evaluation against registered busy bits; no same-cycle bypass from completions.
    always_comb begin
        alu_clear_s = alu_ready
                    & (inflight_q != MAX_INFLIGHT_C)
                    & ~busy_q[src1_s]
                    & ~busy_q[dest_s];
        if (cls_s == CLS_BINARY) begin
            alu_clear_s = alu_clear_s & ~busy_q[src2_s];
        end else begin
            alu_clear_s = alu_clear_s;
        end
        load_clear_s = ~busy_q[dest_s] & data_avail;
    end

    // Issue FSM next-state and strobe outputs.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        fifo_pop     = 1'b0;
        data_pop     = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = 4'h0;
        rf_wdata     = 32'h0000_0000;
        alu_issue    = 1'b0;
        alu_op       = 4'h0;
        alu_src1     = 4'h0;
        alu_src2     = 4'h0;
        alu_dest     = 4'h0;
        illegal_op   = 1'b0;
        issue_mask_s = 16'h0000;
        load_mask_s  = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    inst_d   = fifo_rdata;
                    state_d  = ST_EVAL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EVAL: begin
                case (cls_s)
                    CLS_NONE: begin
                        state_d = ST_IDLE;
                    end
                    CLS_ILLEGAL: begin
                        illegal_op = 1'b1;
                        state_d    = ST_IDLE;
                    end
                    CLS_LOAD: begin
                        if (load_clear_s) begin
                            rf_we       = 1'b1;
                            rf_waddr    = dest_s;
                            rf_wdata    = data_in;
                            data_pop    = 1'b1;
                            load_mask_s = reg_onehot(dest_s);
                            state_d     = ST_IDLE;
                        end else begin
                            state_d     = ST_EVAL;
                        end
                    end
                    CLS_BINARY, CLS_UNARY: begin
                        if (alu_clear_s) begin
                            alu_issue    = 1'b1;
                            alu_op       = op_s;
                            alu_src1     = src1_s;
                            alu_src2     = src2_s;
                            alu_dest     = dest_s;
                            issue_mask_s = reg_onehot(dest_s);
                            state_d      = ST_IDLE;
                        end else begin
                            state_d      = ST_EVAL;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retire pulses: a LOAD commit and an ALU completion always name different registers.
    always_comb begin
        dependency_remove = done_mask_s | load_mask_s;
    end

    // Scoreboard and in-flight count; issue and completion in one cycle cancel out.
    always_comb begin
        busy_d     = (busy_q | issue_mask_s) & ~done_mask_s;
        inflight_d = inflight_q;
        case ({alu_issue, done_hit_s})
            2'b10: begin
                inflight_d = inflight_q + 4'd1;
            end
            2'b01: begin
                if (inflight_q != 4'd0) begin
                    inflight_d = inflight_q - 4'd1;
                end else begin
                    inflight_d = 4'd0;
                end
            end
            default: begin
                inflight_d = inflight_q;
            end
        endcase
    end

    // State, latched header, scoreboard and in-flight registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            inst_q     <= 16'h0000;
            busy_q     <= 16'h0000;
            inflight_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Directed bench for fp_issue_scheduler: a cycle-level behavioural model checks every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_fp_issue_scheduler;

    localparam int MAX_INF = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fifo_empty;
    logic [15:0] fifo_rdata;
    logic        fifo_pop;
    logic        data_avail;
    logic [31:0] data_in;
    logic        data_pop;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        alu_ready;
    logic        alu_issue;
    logic [3:0]  alu_op, alu_src1, alu_src2, alu_dest;
    logic        alu_done;
    logic [3:0]  alu_done_dest;
    logic [15:0] dependency_remove;
    logic        illegal_op;
    logic [15:0] busy_o;

    fp_issue_scheduler #(.MAX_INFLIGHT(MAX_INF)) dut (
        .clk(clk), .n_rst(n_rst),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
        .data_avail(data_avail), .data_in(data_in), .data_pop(data_pop),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_ready(alu_ready), .alu_issue(alu_issue), .alu_op(alu_op),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_dest(alu_dest),
        .alu_done(alu_done), .alu_done_dest(alu_done_dest),
        .dependency_remove(dependency_remove), .illegal_op(illegal_op), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fq[$];
    bit          pop_seen;

    // Model state: whether a header is held, the header, and the register bookkeeping.
    bit          m_hold;
    logic [15:0] m_inst;
    bit   [15:0] m_busy;
    int          m_inflight;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() == 0) ? 16'h0000 : fq[0];
    endtask

    task automatic push(input logic [15:0] v);
        fq.push_back(v);
        refresh();
    endtask

    // Per-cycle model evaluation and full-output comparison at the falling edge.
    task automatic sample();
        bit          e_pop, e_dpop, e_we, e_iss, e_ill, retire, release_inst;
        logic [3:0]  e_waddr, e_op, e_s1, e_s2, e_d;
        logic [31:0] e_wdata;
        logic [15:0] e_dep;
        int          op, d, s1, s2, ddst;
        bit          binary, ok;
        @(negedge clk);
        if (!n_rst) begin
            m_hold = 1'b0; m_inst = 16'h0000; m_busy = 16'h0000; m_inflight = 0;
            pop_seen = 1'b0;
            return;
        end
        e_pop = 1'b0; e_dpop = 1'b0; e_we = 1'b0; e_iss = 1'b0; e_ill = 1'b0;
        e_waddr = 4'h0; e_op = 4'h0; e_s1 = 4'h0; e_s2 = 4'h0; e_d = 4'h0;
        e_wdata = 32'h0; e_dep = 16'h0; release_inst = 1'b0;
        ddst = int'(alu_done_dest);
        retire = alu_done && m_busy[ddst];
        if (retire) e_dep[ddst] = 1'b1;
        op = int'(m_inst[15:12]); d = int'(m_inst[11:8]);
        s1 = int'(m_inst[7:4]);   s2 = int'(m_inst[3:0]);
        if (!m_hold) begin
            e_pop = !fifo_empty;
        end else if (op == 0 || op == 1 || op == 10) begin
            release_inst = 1'b1;
        end else if (op >= 11) begin
            e_ill = 1'b1; release_inst = 1'b1;
        end else if (op == 2) begin
            if (!m_busy[d] && data_avail) begin
                e_we = 1'b1; e_dpop = 1'b1; e_waddr = m_inst[11:8]; e_wdata = data_in;
                e_dep[d] = 1'b1; release_inst = 1'b1;
            end
        end else begin
            binary = (op >= 3 && op <= 5);
            ok = alu_ready && (m_inflight < MAX_INF) && !m_busy[s1] && !m_busy[d]
                 && !(binary && m_busy[s2]);
            if (ok) begin
                e_iss = 1'b1; e_op = m_inst[15:12]; e_d = m_inst[11:8];
                e_s1 = m_inst[7:4]; e_s2 = m_inst[3:0]; release_inst = 1'b1;
            end
        end
        chk("m_pop",     32'(fifo_pop), 32'(e_pop));
        chk("m_load",    32'({rf_we, data_pop, rf_waddr}), 32'({e_we, e_dpop, e_waddr}));
        chk("m_wdata",   rf_wdata, e_wdata);
        chk("m_alu",     32'({alu_issue, alu_op, alu_src1, alu_src2, alu_dest}),
                         32'({e_iss, e_op, e_s1, e_s2, e_d}));
        chk("m_dep",     32'(dependency_remove), 32'(e_dep));
        chk("m_illegal", 32'(illegal_op), 32'(e_ill));
        chk("m_busy",    32'(busy_o), 32'(m_busy));
        pop_seen = fifo_pop;
        if (e_pop) begin m_hold = 1'b1; m_inst = fifo_rdata; end
        if (release_inst) m_hold = 1'b0;
        if (e_iss) begin m_busy[d] = 1'b1; m_inflight++; end
        if (retire) begin m_busy[ddst] = 1'b0; m_inflight--; end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (pop_seen && fq.size() > 0) fq.delete(0);
        refresh();
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'(|{fifo_pop, data_pop, rf_we, rf_waddr, rf_wdata, alu_issue, alu_op,
                        alu_src1, alu_src2, alu_dest, dependency_remove, illegal_op}), 32'h0);
        chk({name, "_busy"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        n_rst = 1'b0; data_avail = 1'b0; data_in = 32'h0; alu_ready = 1'b0;
        alu_done = 1'b0; alu_done_dest = 4'h0; pop_seen = 1'b0;
        m_hold = 1'b0; m_inst = 16'h0; m_busy = 16'h0; m_inflight = 0;
        refresh();
        cycle();
        sample(); chk_all_zero("reset"); adv();

        // Single ADD round trip
        n_rst = 1'b1; alu_ready = 1'b1; push(16'h3123);
        sample(); chk("s1_pop", 32'(fifo_pop), 32'h1); adv();
        sample();
        chk("s1_issue", 32'({alu_issue, alu_op, alu_src1, alu_src2, alu_dest}),
            32'({1'b1, 4'h3, 4'h2, 4'h3, 4'h1}));
        adv();
        alu_done = 1'b1; alu_done_dest = 4'h1;
        sample(); chk("s1_busy", 32'(busy_o), 32'h0002);
        chk("s1_dep", 32'(dependency_remove), 32'h0002); adv();
        alu_done = 1'b0;
        sample(); chk("s1_busy_clr", 32'(busy_o), 32'h0); adv();

        // RAW: NEG r4 <- r1 waits on ADD r1
        push(16'h3123); push(16'h7410);
        cycle();
        sample(); chk("s2_add_issue", 32'(alu_issue), 32'h1); adv();
        for (int k = 1; k <= 4; k++) begin
            sample();
            if (k == 4) chk("s2_stall", 32'(alu_issue), 32'h0);
            adv();
        end
        alu_done = 1'b1; alu_done_dest = 4'h1;
        sample(); chk("s2_dep", 32'(dependency_remove), 32'h0002);
        chk("s2_no_bypass", 32'(alu_issue), 32'h0); adv();
        alu_done = 1'b0;
        sample();
        chk("s2_neg_issue", 32'({alu_issue, alu_op, alu_src1, alu_dest}),
            32'({1'b1, 4'h7, 4'h1, 4'h4}));
        adv();
        alu_done = 1'b1; alu_done_dest = 4'h4; cycle(); alu_done = 1'b0;

        // LOAD waits for data
        push(16'h2500);
        cycle();
        for (int k = 0; k < 3; k++) begin
            sample(); chk("s3_wait", 32'({rf_we, data_pop}), 32'h0); adv();
        end
        data_avail = 1'b1; data_in = 32'h3F80_0000;
        sample();
        chk("s3_load", 32'({rf_we, data_pop, rf_waddr}), 32'({1'b1, 1'b1, 4'h5}));
        chk("s3_wdata", rf_wdata, 32'h3F80_0000);
        chk("s3_dep", 32'(dependency_remove), 32'h0020);
        adv();
        data_avail = 1'b0;
        sample(); chk("s3_done", 32'(rf_we), 32'h0); adv();

        // In-flight cap
        for (int i = 1; i <= 5; i++) push(16'h30EF | 16'(i << 8));
        for (int c = 1; c <= 11; c++) begin
            sample();
            if (c == 11) begin
                chk("s4_cap_stall", 32'(alu_issue), 32'h0);
                chk("s4_busy", 32'(busy_o), 32'h001E);
            end
            adv();
        end
        alu_done = 1'b1; alu_done_dest = 4'h1;
        sample(); chk("s4_dep", 32'(dependency_remove), 32'h0002);
        chk("s4_still_stall", 32'(alu_issue), 32'h0); adv();
        alu_done = 1'b0;
        sample(); chk("s4_fifth", 32'({alu_issue, alu_dest}), 32'({1'b1, 4'h5})); adv();
        push(16'h36EF);
        cycle();
        sample(); adv();
        sample(); chk("s4_cap_again", 32'(alu_issue), 32'h0); adv();

        // Simultaneous issue of r6 and completion of r2
        alu_done = 1'b1; alu_done_dest = 4'h3;
        sample(); chk("s5_dep_r3", 32'(dependency_remove), 32'h0008); adv();
        alu_done_dest = 4'h2;
        sample(); chk("s5_issue", 32'({alu_issue, alu_dest}), 32'({1'b1, 4'h6}));
        chk("s5_dep", 32'(dependency_remove), 32'h0004); adv();
        alu_done = 1'b0;
        sample(); chk("s5_busy", 32'(busy_o), 32'h0070); adv();
        push(16'h37EF); push(16'h38EF);
        cycle();
        sample(); chk("s5_r7", 32'({alu_issue, alu_dest}), 32'({1'b1, 4'h7})); adv();
        cycle();
        sample(); chk("s5_r8_stall", 32'(alu_issue), 32'h0); adv();
        for (int d = 4; d <= 7; d++) begin
            alu_done = 1'b1; alu_done_dest = 4'(d); cycle();
        end
        alu_done = 1'b0; cycle(); cycle();
        alu_done = 1'b1; alu_done_dest = 4'h8; cycle();
        alu_done = 1'b0;
        sample(); chk("s5_drained", 32'(busy_o), 32'h0); adv();

        // Illegal opcode
        push(16'hC000);
        cycle();
        sample(); chk("ill_pulse", 32'({illegal_op, alu_issue}), 32'({1'b1, 1'b0}));
        chk("ill_dep", 32'(dependency_remove), 32'h0); adv();
        sample(); chk("ill_once", 32'(illegal_op), 32'h0); adv();

        // Stray completion must not underflow the in-flight count
        alu_done = 1'b1; alu_done_dest = 4'h9;
        sample(); chk("stray_dep", 32'(dependency_remove), 32'h0); adv();
        alu_done = 1'b0;
        for (int i = 1; i <= 5; i++) push(16'h30EF | 16'(i << 8));
        for (int c = 1; c <= 10; c++) begin
            sample();
            if (c == 10) chk("stray_no_underflow", 32'(alu_issue), 32'h0);
            adv();
        end

        // Reset mid-stall discards the held ADD and clears the scoreboard
        n_rst = 1'b0;
        sample(); chk_all_zero("mid_reset"); adv();
        n_rst = 1'b1; push(16'h31EF);
        sample(); chk("post_rst_pop", 32'(fifo_pop), 32'h1); adv();
        sample(); chk("post_rst_issue", 32'({alu_issue, alu_dest}), 32'({1'b1, 4'h1})); adv();
        alu_done = 1'b1; alu_done_dest = 4'h1; cycle();
        alu_done = 1'b0; cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_issue_scheduler.md
Name: fp_issue_scheduler

Overview:
- In-order issue stage directly downstream of the instruction parser.
- Pops 16-bit instruction headers from the instruction FIFO the parser fills, decodes them, and enforces RAW/WAW hazards with a per-register busy scoreboard.
- Issues arithmetic ops to the FP ALU and writes LOAD data from the parser's data buffer into the register file.
- Drives the 16-bit dependency_remove one-hot back to the parser's per-register counters on every retirement.

Parameters:
MAX_INFLIGHT, 4, maximum ALU ops issued but not yet completed (1..15)

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
fifo_empty  in  1  instruction FIFO empty
fifo_rdata  in  16  head of instruction FIFO (show-ahead); [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2
fifo_pop  out  1  pop instruction FIFO
data_avail  in  1  parser data buffer non-empty
data_in  in  32  parser data buffer head word
data_pop  out  1  pop data buffer (drives parser read_data_enable)
rf_we  out  1  register file write enable (LOAD)
rf_waddr  out  4  register file write address
rf_wdata  out  32  register file write data
alu_ready  in  1  ALU can accept an op this cycle
alu_issue  out  1  issue strobe
alu_op  out  4  opcode
alu_src1  out  4  source register 1
alu_src2  out  4  source register 2
alu_dest  out  4  destination register
alu_done  in  1  ALU completion strobe
alu_done_dest  in  4  destination of the completing op
dependency_remove  out  16  one-hot retire pulse per register
illegal_op  out  1  one-cycle pulse on undefined opcode
busy_o  out  16  scoreboard, for debug

Behaviour:
- Reset: state IDLE, inst_reg=0, busy=0, inflight=0. All outputs 0.
- Opcodes:
  - NOP 0, STORE2 1, STORE1 A: retire with no action.
  - LOAD 2.
  - Binary: ADD 3, SUB 4, MUL 5.
  - Unary: SIN 6, NEG 7, ABS 8, MOVE 9. src2 is ignored for hazard checks.
  - B–F are illegal.
- FSM:
  - IDLE: if !fifo_empty, assert fifo_pop for 1 cycle, latch fifo_rdata into inst_reg, go to EVAL. Otherwise stay.
  - EVAL, NOP/STORE: return to IDLE. No outputs asserted.
  - EVAL, illegal opcode: illegal_op=1 for this cycle, then IDLE.
  - EVAL, LOAD: stall while busy[dest] or !data_avail. When clear, in one cycle assert rf_we=1, rf_waddr=dest, rf_wdata=data_in, data_pop=1 and dependency_remove[dest]=1, then go to IDLE.
  - EVAL, ALU op: stall while any of these holds: !alu_ready, inflight==MAX_INFLIGHT, busy[src1], busy[src2] (binary ops only), busy[dest]. When clear, assert alu_issue=1 with op/src/dest from inst_reg for one cycle. On the edge, set busy[dest] and increment inflight, then go to IDLE.
- Outputs in EVAL are combinational from registered state, scoreboard and inputs. alu_* fields are 0 whenever alu_issue=0.
- Throughput: at most 1 instruction per 2 cycles. FIFO pop to issue takes 1 cycle minimum.
- Completion (every state):
  - alu_done with busy[alu_done_dest]=1: dependency_remove[alu_done_dest]=1 in the same cycle. On the edge, clear busy and decrement inflight.
  - alu_done with busy[alu_done_dest]=0: ignored entirely (no pulse, no decrement).
- Hazard checks use registered busy; there is no same-cycle bypass. A completion that frees a needed register lets issue proceed the following cycle.
- Simultaneous issue and completion:
  - inflight is unchanged.
  - The two registers always differ, because issue requires !busy[dest].
  - dependency_remove may carry one LOAD bit and one ALU bit together (OR'd, always different registers).
- inflight never exceeds MAX_INFLIGHT and never underflows.
- Reset mid-operation clears the scoreboard and discards a latched instruction. The ALU is reset by the same n_rst.

Test Plan:
- Reset, FIFO holds ADD (0x3123), alu_ready=1 -> fifo_pop at cycle 1; alu_issue at cycle 2 with op=3, dest=1, src1=2, src2=3; busy_o=0x0002; alu_done dest=1 -> dependency_remove=0x0002, busy_o=0.
- RAW: ADD r1<-r2,r3 then NEG r4<-r1; ALU completes r1 after 5 cycles -> NEG stalls in EVAL; alu_issue for NEG exactly 1 cycle after the dependency_remove=0x0002 pulse.
- LOAD 0x2500 with data_avail=0 for 3 cycles then data_in=0x3F800000 -> rf_we, data_pop and dependency_remove=0x0020 all asserted in the first cycle data_avail=1; rf_waddr=5.
- MAX_INFLIGHT=4: five independent ADDs to r1..r5, no completions -> four issues, fifth stalls; one alu_done -> fifth issues the next cycle; inflight returns to 4.
- Same-cycle issue and completion: issue r6 while alu_done dest=2 -> dependency_remove=0x0004, busy gains bit 6, inflight unchanged. Separately, opcode 0xC -> illegal_op pulse, no issue, no dependency_remove.
- Stray alu_done dest=9 with busy=0 -> dependency_remove stays 0, inflight stays 0; assert n_rst mid-stall -> all outputs 0, busy_o=0.
